// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit framer.
package uart_pkg;

    // Raw encodings of the parity_mode input.
    localparam logic [2:0] PM_NONE  = 3'd0;
    localparam logic [2:0] PM_EVEN  = 3'd1;
    localparam logic [2:0] PM_ODD   = 3'd2;
    localparam logic [2:0] PM_MARK  = 3'd3;
    localparam logic [2:0] PM_SPACE = 3'd4;

    typedef enum logic [2:0] {
        PAR_NONE  = PM_NONE,
        PAR_EVEN  = PM_EVEN,
        PAR_ODD   = PM_ODD,
        PAR_MARK  = PM_MARK,
        PAR_SPACE = PM_SPACE
    } parity_mode_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    // Unused encodings 5..7 fall back to no parity.
    function automatic parity_mode_t decode_parity_mode(input logic [2:0] raw);
        case (raw)
            PM_EVEN:  return PAR_EVEN;
            PM_ODD:   return PAR_ODD;
            PM_MARK:  return PAR_MARK;
            PM_SPACE: return PAR_SPACE;
            default:  return PAR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_framer_if.sv
// Character handshake, frame configuration and serial line of the UART framer.
interface uart_tx_framer_if #(
    parameter int DWIDTH = 8
);
    logic [DWIDTH-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [2:0]        parity_mode;
    logic              stop2;
    logic              txd;
    logic              tx_busy;
    logic              tx_done;

    modport master (
        output tx_data, tx_valid, parity_mode, stop2,
        input  tx_ready, txd, tx_busy, tx_done
    );

    modport slave (
        input  tx_data, tx_valid, parity_mode, stop2,
        output tx_ready, txd, tx_busy, tx_done
    );
endinterface

// File: rtl/uart_parity_unit.sv
// Parity bit generator for one character under the selected parity mode.
module uart_parity_unit
    import uart_pkg::*;
#(
    parameter int DWIDTH = 8
) (
    input  logic [DWIDTH-1:0] data,
    input  parity_mode_t      mode,
    output logic              parity_bit
);

    // Pick the bit that gives the whole data+parity group the requested parity.
    always_comb begin
        parity_bit = 1'b0;
        case (mode)
            PAR_EVEN:  parity_bit = ^data;
            PAR_ODD:   parity_bit = ~^data;
            PAR_MARK:  parity_bit = 1'b1;
            PAR_SPACE: parity_bit = 1'b0;
            default:   parity_bit = 1'b0;
        endcase
    end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, DWIDTH data bits LSB first, optional parity,
// one or two stop bits; back-to-back frames with no idle gap.
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int DWIDTH       = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic             HCLK,
    input  logic             HRESET,
    uart_tx_framer_if.slave  bus
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = $clog2(DWIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DWIDTH - 1);

    tx_state_t         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              stop_idx_q, stop_idx_d;
    logic [DWIDTH-1:0] data_q, data_d;
    logic [DWIDTH-1:0] shift_q, shift_d;
    parity_mode_t      mode_q, mode_d;
    logic              stop2_q, stop2_d;
    logic              txd_q, txd_d;
    logic              parity_bit;
    logic              bit_end;
    logic              last_stop;
    logic              tx_ready;
    logic              accept;

    uart_parity_unit #(
        .DWIDTH (DWIDTH)
    ) u_parity (
        .data       (data_q),
        .mode       (mode_q),
        .parity_bit (parity_bit)
    );

    assign bit_end   = (cnt_q == LAST_CNT);
    assign last_stop = (state_q == ST_STOP) && bit_end && (stop_idx_q == stop2_q);
    assign tx_ready  = (state_q == ST_IDLE) || last_stop;
    assign accept    = bus.tx_valid && tx_ready;

    assign bus.tx_ready = tx_ready;
    assign bus.tx_done  = last_stop;
    assign bus.tx_busy  = (state_q != ST_IDLE);
    assign bus.txd      = txd_q;

    // Next-state, bit timing and next serial level.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        stop_idx_d = stop_idx_q;
        data_d     = data_q;
        shift_d    = shift_q;
        mode_d     = mode_q;
        stop2_d    = stop2_q;
        txd_d      = txd_q;

        if (state_q != ST_IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                    idx_d   = '0;
                    txd_d   = shift_q[0];
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (idx_q == LAST_IDX) begin
                        if (mode_q != PAR_NONE) begin
                            state_d = ST_PARITY;
                            txd_d   = parity_bit;
                        end else begin
                            state_d    = ST_STOP;
                            stop_idx_d = 1'b0;
                            txd_d      = 1'b1;
                        end
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        shift_d = shift_q >> 1;
                        txd_d   = shift_q[1];
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d    = ST_STOP;
                    stop_idx_d = 1'b0;
                    txd_d      = 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (stop_idx_q == stop2_q) begin
                        state_d = ST_IDLE;
                        txd_d   = 1'b1;
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Accept is only possible in IDLE or the final stop cycle, so it
        // overrides whatever those states decided and opens a new frame.
        if (accept) begin
            state_d = ST_START;
            cnt_d   = '0;
            txd_d   = 1'b0;
            data_d  = bus.tx_data;
            shift_d = bus.tx_data;
            mode_d  = decode_parity_mode(bus.parity_mode);
            stop2_d = bus.stop2;
        end
    end

    // State, counters, latched frame configuration and registered serial line.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            stop_idx_q <= 1'b0;
            data_q     <= '0;
            shift_q    <= '0;
            mode_q     <= PAR_NONE;
            stop2_q    <= 1'b0;
            txd_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            stop_idx_q <= stop_idx_d;
            data_q     <= data_d;
            shift_q    <= shift_d;
            mode_q     <= mode_d;
            stop2_q    <= stop2_d;
            txd_q      <= txd_d;
        end
    end

    // While the parity bit is on the line, data plus parity must match the mode.
    a_parity_ok: assert property (
        @(posedge HCLK) disable iff (HRESET)
        (state_q == ST_PARITY && (mode_q == PAR_EVEN || mode_q == PAR_ODD))
            |-> ((^data_q ^ txd_q) == (mode_q == PAR_ODD))
    );

endmodule
